// File: rtl/seq_prog_det_if.sv
// Bus bundle for the programmable sequence detector: pattern/length config,
// valid-qualified symbol input, match pulse and match counter.
interface seq_prog_det_if #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 8,
   parameter int CNT_WIDTH  = 8
);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic                  cfg_sym_we;
   logic [IDX_W-1:0]      cfg_idx;
   logic [DATA_WIDTH-1:0] cfg_symbol;
   logic                  cfg_len_we;
   logic [LEN_W-1:0]      cfg_len;
   logic                  overlap;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_symbol;
   logic                  match;
   logic [CNT_WIDTH-1:0]  match_count;
   logic                  cnt_clear;

   modport master (
      output cfg_sym_we, cfg_idx, cfg_symbol, cfg_len_we, cfg_len,
      output overlap, in_valid, in_symbol, cnt_clear,
      input  match, match_count
   );

   modport slave (
      input  cfg_sym_we, cfg_idx, cfg_symbol, cfg_len_we, cfg_len,
      input  overlap, in_valid, in_symbol, cnt_clear,
      output match, match_count
   );
endinterface

// File: rtl/seq_prog_det.sv
// Run-time programmable sequence detector (reset pattern "12131", length 5).
// Optional saturating match counter enabled by defining SEQ_MATCH_COUNT_EN.
module seq_prog_det_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 8,
   localparam int IDX_W     = $clog2(MAX_LEN),
   localparam int LEN_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sym_we,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] symbol,
   input  logic                  len_we,
   input  logic [LEN_W-1:0]      len_in,
   output logic [DATA_WIDTH-1:0] pattern [MAX_LEN],
   output logic [LEN_W-1:0]      len,
   output logic                  flush
);
   logic sym_ok;
   logic len_ok;

   function automatic logic [DATA_WIDTH-1:0] reset_sym(input int i);
      case (i)
         0, 2, 4: return DATA_WIDTH'(8'h31);
         1:       return DATA_WIDTH'(8'h32);
         3:       return DATA_WIDTH'(8'h33);
         default: return '0;
      endcase
   endfunction

   assign sym_ok = sym_we && (int'(idx) < MAX_LEN);
   assign len_ok = len_we && (len_in != '0) && (int'(len_in) <= MAX_LEN);
   // only writes that actually land restart the symbol window
   assign flush  = sym_ok || len_ok;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < MAX_LEN; i++) pattern[i] <= reset_sym(i);
         len <= LEN_W'(5);
      end else begin
         for (int i = 0; i < MAX_LEN; i++)
            if (sym_ok && idx == IDX_W'(i)) pattern[i] <= symbol;
         if (len_ok) len <= len_in;
      end
   end
endmodule

module seq_prog_det #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_LEN    = 8,
   parameter int CNT_WIDTH  = 8
) (
   input logic           clk,
   input logic           reset_n,
   seq_prog_det_if.slave bus
);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int LEN_W = $clog2(MAX_LEN + 1);

   logic [DATA_WIDTH-1:0] pattern [MAX_LEN];
   logic [LEN_W-1:0]      len;
   logic                  flush;
   logic [DATA_WIDTH-1:0] hist [MAX_LEN-1];
   logic [DATA_WIDTH-1:0] cand [MAX_LEN];
   logic [LEN_W-1:0]      fill;
   logic [LEN_W:0]        fill_p1;
   logic                  accept;
   logic                  hit;
   logic                  match_set;
   logic                  match_q;

   seq_prog_det_cfg #(.DATA_WIDTH(DATA_WIDTH), .MAX_LEN(MAX_LEN)) u_cfg (
      .clk     (clk),
      .reset_n (reset_n),
      .sym_we  (bus.cfg_sym_we),
      .idx     (bus.cfg_idx),
      .symbol  (bus.cfg_symbol),
      .len_we  (bus.cfg_len_we),
      .len_in  (bus.cfg_len),
      .pattern (pattern),
      .len     (len),
      .flush   (flush)
   );

   assign accept    = bus.in_valid && !flush;
   assign fill_p1   = {1'b0, fill} + (LEN_W + 1)'(1);
   assign match_set = accept && hit;

   // cand[0] is the incoming symbol, cand[k] the k-th older accepted one
   always_comb begin
      cand[0] = bus.in_symbol;
      for (int k = 1; k < MAX_LEN; k++) cand[k] = hist[k-1];
   end

   always_comb begin
      hit = (fill_p1 >= {1'b0, len});
      for (int k = 0; k < MAX_LEN; k++)
         if (k < int'(len) && cand[k] != pattern[IDX_W'(int'(len) - 1 - k)]) hit = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < MAX_LEN - 1; k++) hist[k] <= '0;
         fill    <= '0;
         match_q <= 1'b0;
      end else begin
         match_q <= match_set;
         if (flush) begin
            fill <= '0;
         end else if (accept) begin
            hist[0] <= bus.in_symbol;
            for (int k = 1; k < MAX_LEN - 1; k++) hist[k] <= hist[k-1];
            if (hit && !bus.overlap)        fill <= '0;
            else if (int'(fill) < MAX_LEN)  fill <= fill + LEN_W'(1);
         end
      end
   end

   assign bus.match = match_q;

`ifdef SEQ_MATCH_COUNT_EN
   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count <= '0;
      else if (bus.cnt_clear)
         count <= match_set ? CNT_WIDTH'(1) : '0;
      else if (match_set && count != '1)
         count <= count + CNT_WIDTH'(1);
   end

   assign bus.match_count = count;
`else
   logic unused_cnt_clear;
   assign unused_cnt_clear = bus.cnt_clear;
   assign bus.match_count  = '0;
`endif
endmodule

// File: tb/tb_seq_prog_det.sv
// Randomized + directed bench for seq_prog_det against a queue-based reference model.
// Counter expectations follow SEQ_MATCH_COUNT_EN when it is defined for the build.
module tb_seq_prog_det;
   localparam int DW    = 8;
   localparam int ML    = 8;
   localparam int CW    = 2;
   localparam int IDX_W = $clog2(ML);
   localparam int LEN_W = $clog2(ML + 1);
   localparam int CMAX  = (1 << CW) - 1;
`ifdef SEQ_MATCH_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   seq_prog_det_if #(.DATA_WIDTH(DW), .MAX_LEN(ML), .CNT_WIDTH(CW)) bus ();

   seq_prog_det #(.DATA_WIDTH(DW), .MAX_LEN(ML), .CNT_WIDTH(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulse  = 0;
   bit ovl      = 1'b1;

   logic [7:0] m_pat [ML];
   int         m_len;
   logic [7:0] m_q [$];
   int         m_cnt;
   logic [7:0] alphabet [3] = '{8'h31, 8'h32, 8'h33};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ML; i++) m_pat[i] = 8'h00;
      m_pat[0] = 8'h31; m_pat[1] = 8'h32; m_pat[2] = 8'h31; m_pat[3] = 8'h33; m_pat[4] = 8'h31;
      m_len = 5;
      m_q.delete();
      m_cnt = 0;
   endtask

   task automatic cycle(input bit v, input logic [7:0] s, input bit swe, input int idx,
                        input logic [7:0] sd, input bit lwe, input int l, input bit clr);
      bit sym_ok, len_ok, hit;
      bus.in_valid   = v;
      bus.in_symbol  = s;
      bus.cfg_sym_we = swe;
      bus.cfg_idx    = IDX_W'(idx);
      bus.cfg_symbol = sd;
      bus.cfg_len_we = lwe;
      bus.cfg_len    = LEN_W'(l);
      bus.cnt_clear  = clr;
      bus.overlap    = ovl;
      sym_ok = swe && idx < ML;
      len_ok = lwe && l >= 1 && l <= ML;
      hit    = 1'b0;
      if (sym_ok || len_ok) begin
         if (sym_ok) m_pat[idx] = sd;
         if (len_ok) m_len = l;
         m_q.delete();
      end else if (v) begin
         m_q.push_back(s);
         if (m_q.size() > ML) void'(m_q.pop_front());
         if (m_q.size() >= m_len) begin
            hit = 1'b1;
            for (int k = 0; k < m_len; k++)
               if (m_q[m_q.size() - m_len + k] != m_pat[k]) hit = 1'b0;
         end
         if (hit && !ovl) m_q.delete();
      end
      if (CNT_EN) begin
         if (clr)                     m_cnt = hit ? 1 : 0;
         else if (hit && m_cnt < CMAX) m_cnt++;
      end
      @(posedge clk);
      #1;
      if (bus.match) n_pulse++;
      check_val("match", 32'(bus.match), 32'(hit));
      check_val("match_count", 32'(bus.match_count), 32'(m_cnt));
      bus.in_valid   = 1'b0;
      bus.cfg_sym_we = 1'b0;
      bus.cfg_len_we = 1'b0;
      bus.cnt_clear  = 1'b0;
   endtask

   task automatic feed(input logic [7:0] s, input bit clr = 1'b0);
      cycle(1'b1, s, 1'b0, 0, 8'h00, 1'b0, 0, clr);
   endtask

   task automatic feed_str(input string str);
      for (int i = 0; i < str.len(); i++) feed(str[i]);
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
   endtask

   task automatic wr_sym(input int i, input logic [7:0] d);
      cycle(1'b0, 8'h00, 1'b1, i, d, 1'b0, 0, 1'b0);
   endtask

   task automatic wr_len(input int l);
      cycle(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b1, l, 1'b0);
   endtask

   task automatic do_reset();
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_val("rst_match", 32'(bus.match), 32'd0);
      check_val("rst_count", 32'(bus.match_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      n_pulse = 0;
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_symbol  = '0;
      bus.cfg_sym_we = 1'b0;
      bus.cfg_idx    = '0;
      bus.cfg_symbol = '0;
      bus.cfg_len_we = 1'b0;
      bus.cfg_len    = '0;
      bus.cnt_clear  = 1'b0;
      bus.overlap    = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("init_match", 32'(bus.match), 32'd0);
      check_val("init_count", 32'(bus.match_count), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // basic detect of the reset pattern
      ovl = 1'b1;
      feed_str("1213");
      check_val("t1_no_early", 32'(n_pulse), 32'd0);
      feed("1");
      check_val("t1_hit", 32'(bus.match), 32'd1);
      idle();
      check_val("t1_one_pulse", 32'(n_pulse), 32'd1);

      // overlap vs non-overlap
      do_reset();
      ovl = 1'b1;
      feed_str("121312131");
      check_val("t2_ovl_pulses", 32'(n_pulse), 32'd2);
      do_reset();
      ovl = 1'b0;
      feed_str("121312131");
      check_val("t2_novl_pulses", 32'(n_pulse), 32'd1);
      ovl = 1'b1;

      // custom pattern and rejected lengths
      do_reset();
      wr_len(3);
      wr_sym(0, 8'hA5); wr_sym(1, 8'h00); wr_sym(2, 8'hFF);
      feed(8'hA5); feed(8'h00); feed(8'h00); feed(8'hA5); feed(8'h00); feed(8'hFF);
      check_val("t3_hit", 32'(bus.match), 32'd1);
      check_val("t3_pulses", 32'(n_pulse), 32'd1);
      wr_len(0);
      wr_len(ML + 1);
      feed(8'hA5); feed(8'h00); feed(8'hFF);
      check_val("t3_len_kept", 32'(bus.match), 32'd1);

      // idle gaps and cfg collision
      do_reset();
      feed_str("121");
      repeat (4) idle();
      feed_str("31");
      check_val("t4_gap_hit", 32'(bus.match), 32'd1);
      n_pulse = 0;
      feed_str("1213");
      cycle(1'b1, 8'h31, 1'b1, 5, 8'h00, 1'b0, 0, 1'b0);
      feed("1");
      check_val("t4_collide", 32'(n_pulse), 32'd0);

      // async reset mid-pulse and pattern restore
      do_reset();
      feed_str("12131");
      do_reset();
      wr_sym(0, 8'h77);
      feed_str("1213");
      do_reset();
      feed("1");
      check_val("t5_after_rst", 32'(bus.match), 32'd0);
      feed_str("2131");
      check_val("t5_pat_restored", 32'(bus.match), 32'd1);

      // counter saturation and clear
      do_reset();
      feed_str("12131");
      repeat (4) feed_str("2131");
      check_val("t6_sat", 32'(bus.match_count), CNT_EN ? 32'd3 : 32'd0);
      feed_str("213");
      feed("1", 1'b1);
      check_val("t6_clr_hit", 32'(bus.match_count), CNT_EN ? 32'd1 : 32'd0);
      cycle(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 0, 1'b1);
      check_val("t6_clr", 32'(bus.match_count), 32'd0);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         bit v, swe, lwe, clr;
         int idx, l;
         logic [7:0] s, sd;
         v   = $urandom_range(0, 3) != 0;
         s   = alphabet[$urandom_range(0, 2)];
         swe = $urandom_range(0, 39) == 0;
         idx = $urandom_range(0, ML - 1);
         sd  = alphabet[$urandom_range(0, 2)];
         lwe = $urandom_range(0, 39) == 0;
         l   = $urandom_range(0, ML + 1);
         if (lwe && (l < 1 || l > ML)) v = 1'b0;
         clr = $urandom_range(0, 49) == 0;
         if ($urandom_range(0, 49) == 0) ovl = !ovl;
         cycle(v, s, swe, idx, sd, lwe, l, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
